// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled tick, programmable step rate, blink/count/chase/breathe patterns.
// leds are registered one cycle after the step (or mode change) cycle; no backpressure, free running.
module led_pattern_gen #(
  parameter int NUM_LEDS   = 12,
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 1000,
  parameter int STEP_TICKS = 100,
  parameter int PWM_BITS   = 8
) (
  input  logic                clkin,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [3:0]          rate,
  output logic [NUM_LEDS-1:0] leds,
  output logic                tick
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PSW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW   = $clog2(16 * STEP_TICKS + 1);
  localparam int POSW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [PSW-1:0]      PS_MAX  = PSW'(DIV - 1);
  localparam logic [POSW-1:0]     POS_MAX = POSW'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0] DMAX    = '1;

  typedef enum logic [1:0] {
    M_BLINK   = 2'd0,
    M_COUNT   = 2'd1,
    M_CHASE   = 2'd2,
    M_BREATHE = 2'd3
  } mode_e;

  logic [PSW-1:0]      presc_q, presc_d;
  logic                tick_q, tick_d;
  logic [SW-1:0]       step_cnt_q, step_cnt_d;
  logic [31:0]         step_lim;
  logic                at_lim;
  logic                step;

  mode_e               mode_q, mode_d;
  logic                tog_q, tog_d;
  logic [NUM_LEDS-1:0] cnt_q, cnt_d;
  logic [POSW-1:0]     pos_q, pos_d;
  logic                dir_q, dir_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                ddir_q, ddir_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                pat_clear;

  logic [NUM_LEDS-1:0] leds_q, leds_d;

  // Prescaler: tick is registered, so it lands DIV cycles after enable rises.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (!enable) begin
      presc_d = '0;
    end else begin
      tick_d  = (presc_q == PS_MAX);
      presc_d = tick_d ? '0 : presc_q + PSW'(1);
    end
  end

  // Limit is re-evaluated every tick; >= makes a shrunken limit wrap on the next tick.
  assign step_lim = (({28'd0, rate} + 32'd1) * $unsigned(STEP_TICKS)) - 32'd1;
  assign at_lim   = (32'(step_cnt_q) >= step_lim);
  assign step     = enable && tick_q && at_lim;

  always_comb begin
    step_cnt_d = step_cnt_q;
    if (!enable) begin
      step_cnt_d = '0;
    end else if (tick_q) begin
      step_cnt_d = at_lim ? '0 : step_cnt_q + SW'(1);
    end
  end

  // Pattern state; a mode change clears everything and swallows a coincident step.
  assign pat_clear = !enable || (mode_e'(mode) != mode_q);

  always_comb begin
    mode_d = mode_q;
    tog_d  = tog_q;
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    duty_d = duty_q;
    ddir_d = ddir_q;
    pwm_d  = pwm_q;
    if (pat_clear) begin
      mode_d = enable ? mode_e'(mode) : M_BLINK;
      tog_d  = 1'b0;
      cnt_d  = '0;
      pos_d  = '0;
      dir_d  = 1'b0;
      duty_d = '0;
      ddir_d = 1'b0;
      pwm_d  = '0;
    end else begin
      pwm_d = pwm_q + PWM_BITS'(1);
      if (step) begin
        case (mode_q)
          M_BLINK: tog_d = ~tog_q;
          M_COUNT: cnt_d = cnt_q + NUM_LEDS'(1);
          M_CHASE: begin
            if (NUM_LEDS > 1) begin
              if (!dir_q) begin
                if (pos_q == POS_MAX) begin
                  dir_d = 1'b1;
                  pos_d = pos_q - POSW'(1);
                end else begin
                  pos_d = pos_q + POSW'(1);
                end
              end else begin
                if (pos_q == '0) begin
                  dir_d = 1'b0;
                  pos_d = pos_q + POSW'(1);
                end else begin
                  pos_d = pos_q - POSW'(1);
                end
              end
            end
          end
          M_BREATHE: begin
            if (!ddir_q) begin
              if (duty_q == DMAX) begin
                ddir_d = 1'b1;
                duty_d = duty_q - PWM_BITS'(1);
              end else begin
                duty_d = duty_q + PWM_BITS'(1);
              end
            end else begin
              if (duty_q == '0) begin
                ddir_d = 1'b0;
                duty_d = duty_q + PWM_BITS'(1);
              end else begin
                duty_d = duty_q - PWM_BITS'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Rendered from next-state so the first cycle of a new mode shows its reset pattern.
  always_comb begin
    leds_d = '0;
    if (enable) begin
      case (mode_d)
        M_BLINK:   leds_d = {NUM_LEDS{tog_d}};
        M_COUNT:   leds_d = cnt_d;
        M_CHASE:   leds_d = NUM_LEDS'(1) << pos_d;
        M_BREATHE: leds_d = {NUM_LEDS{pwm_d < duty_d}};
        default:   leds_d = '0;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      step_cnt_q <= '0;
      mode_q     <= M_BLINK;
      tog_q      <= 1'b0;
      cnt_q      <= '0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      duty_q     <= '0;
      ddir_q     <= 1'b0;
      pwm_q      <= '0;
      leds_q     <= '0;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      step_cnt_q <= step_cnt_d;
      mode_q     <= mode_d;
      tog_q      <= tog_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      duty_q     <= duty_d;
      ddir_q     <= ddir_d;
      pwm_q      <= pwm_d;
      leds_q     <= leds_d;
    end
  end

  assign leds = leds_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with DIV=10, STEP_TICKS=2, PWM_BITS=3, four LEDs.
module tb_led_pattern_gen;

  logic       clkin = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] rate;
  logic [3:0] leds;
  logic       tick;

  int total = 0;
  int bad   = 0;

  led_pattern_gen #(
    .NUM_LEDS  (4),
    .CLK_HZ    (1000),
    .TICK_HZ   (100),
    .STEP_TICKS(2),
    .PWM_BITS  (3)
  ) dut (
    .clkin  (clkin),
    .reset_n(reset_n),
    .enable (enable),
    .mode   (mode),
    .rate   (rate),
    .leds   (leds),
    .tick   (tick)
  );

  always #5 clkin = ~clkin;

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    enable  = 1'b0;
    mode    = 2'd0;
    rate    = 4'd0;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (leds !== 4'b0000) begin bad++; $display("FAIL reset_leds got=%b want=0000", leds); end
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", tick); end
    adv(3);
    reset_n = 1'b1;
  endtask

  task automatic test_enable_gate();
    int ticks_seen = 0;
    int lit_seen   = 0;
    int n          = 0;
    bit got        = 0;
    for (int i = 0; i < 100; i++) begin
      adv(1);
      if (tick !== 1'b0) ticks_seen++;
      if (leds !== 4'b0000) lit_seen++;
    end
    total++;
    if (ticks_seen !== 0) begin bad++; $display("FAIL disabled_tick got=%0d want=0", ticks_seen); end
    total++;
    if (lit_seen !== 0) begin bad++; $display("FAIL disabled_leds got=%0d want=0", lit_seen); end
    enable = 1'b1;
    while (!got && n < 30) begin
      adv(1);
      n++;
      if (tick === 1'b1) got = 1;
    end
    total++;
    if (!got || n !== 10) begin bad++; $display("FAIL first_tick got=%0d want=10 (seen=%0d)", n, got); end
  endtask

  task automatic test_blink();
    logic [3:0] prev_v, new_v;
    adv(10);
    for (int m = 1; m <= 3; m++) begin
      prev_v = (m % 2 == 0) ? 4'b1111 : 4'b0000;
      new_v  = (m % 2 == 1) ? 4'b1111 : 4'b0000;
      total++;
      if (leds !== prev_v) begin bad++; $display("FAIL blink_hold%0d got=%b want=%b", m, leds, prev_v); end
      adv(1);
      total++;
      if (leds !== new_v) begin bad++; $display("FAIL blink_step%0d got=%b want=%b", m, leds, new_v); end
      if (m < 3) adv(19);
    end
  endtask

  task automatic test_chase();
    logic [3:0] exp_v [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0100, 4'b0010, 4'b0001, 4'b0010};
    mode = 2'd2;
    adv(1);
    total++;
    if (leds !== exp_v[0]) begin bad++; $display("FAIL chase_start got=%b want=%b", leds, exp_v[0]); end
    adv(18);
    for (int m = 1; m <= 7; m++) begin
      total++;
      if (leds !== exp_v[m-1]) begin bad++; $display("FAIL chase_hold%0d got=%b want=%b", m, leds, exp_v[m-1]); end
      adv(1);
      total++;
      if (leds !== exp_v[m]) begin bad++; $display("FAIL chase_step%0d got=%b want=%b", m, leds, exp_v[m]); end
      if (m < 7) adv(19);
    end
  endtask

  task automatic test_count();
    logic [3:0] prev_v, new_v;
    mode = 2'd1;
    rate = 4'd1;
    adv(1);
    total++;
    if (leds !== 4'b0000) begin bad++; $display("FAIL count_start got=%b want=0000", leds); end
    adv(38);
    for (int v = 1; v <= 16; v++) begin
      prev_v = 4'((v - 1) % 16);
      new_v  = 4'(v % 16);
      total++;
      if (leds !== prev_v) begin bad++; $display("FAIL count_hold%0d got=%b want=%b", v, leds, prev_v); end
      adv(1);
      total++;
      if (leds !== new_v) begin bad++; $display("FAIL count_step%0d got=%b want=%b", v, leds, new_v); end
      if (v < 16) adv(39);
    end
  endtask

  task automatic test_breathe();
    int duty, pwm, ones;
    logic [3:0] want;
    mode = 2'd3;
    rate = 4'd0;
    for (int s = 0; s <= 14; s++) begin
      duty = (s <= 7) ? s : 14 - s;
      ones = 0;
      adv(1);
      for (int i = 0; i < 8; i++) begin
        adv(1);
        pwm  = (1 + 20 * s + i) % 8;
        want = (pwm < duty) ? 4'b1111 : 4'b0000;
        total++;
        if (leds !== want) begin bad++; $display("FAIL breathe_s%0d_i%0d got=%b want=%b", s, i, leds, want); end
        if (leds === 4'b1111) ones++;
      end
      total++;
      if (ones !== duty) begin bad++; $display("FAIL breathe_on_cycles_s%0d got=%0d want=%0d", s, ones, duty); end
      adv(11);
    end
  endtask

  task automatic test_mode_switch();
    mode = 2'd2;
    adv(1);
    total++;
    if (leds !== 4'b0001) begin bad++; $display("FAIL switch_chase_start got=%b want=0001", leds); end
    adv(39);
    total++;
    if (leds !== 4'b0100) begin bad++; $display("FAIL switch_chase_pos2 got=%b want=0100", leds); end
    adv(5);
    total++;
    if (leds !== 4'b0100) begin bad++; $display("FAIL switch_pre got=%b want=0100", leds); end
    mode = 2'd1;
    adv(1);
    total++;
    if (leds !== 4'b0000) begin bad++; $display("FAIL switch_cleared got=%b want=0000", leds); end
    adv(2);
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL switch_tick_before got=%b want=0", tick); end
    adv(1);
    total++;
    if (tick !== 1'b1) begin bad++; $display("FAIL switch_tick_phase got=%b want=1", tick); end
    adv(1);
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL switch_tick_after got=%b want=0", tick); end
    adv(10);
    total++;
    if (leds !== 4'b0001) begin bad++; $display("FAIL switch_count_step got=%b want=0001", leds); end
  endtask

  task automatic test_async_reset();
    #3 reset_n = 1'b0;
    #1;
    total++;
    if (leds !== 4'b0000) begin bad++; $display("FAIL async_reset_leds got=%b want=0000", leds); end
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL async_reset_tick got=%b want=0", tick); end
    adv(2);
    reset_n = 1'b1;
    adv(3);
    total++;
    if (leds !== 4'b0000) begin bad++; $display("FAIL post_reset_leds got=%b want=0000", leds); end
  endtask

  initial begin
    test_reset();
    test_enable_gate();
    test_blink();
    test_chase();
    test_count();
    test_breathe();
    test_mode_switch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
